mpu_op_sequencer: RTL and testbench

//  Front-end controller for the MPU load/store datapath. Accepts one operation at a time (NOP/LOAD/STORE)

---
 rtl/mpu_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mpu_op_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_op_sequencer.sv
// Front-end sequencer for the MPU load/store datapath: takes one NOP/LOAD/STORE at a time,
// starts the matching unit, waits for completion or timeout, and tracks which matrix registers hold data.
package mpu_op_pkg;
  typedef enum logic [1:0] {
    MPU_NOP   = 2'd0,
    MPU_LOAD  = 2'd1,
    MPU_STORE = 2'd2
  } mpu_operation_t;
endpackage

module mpu_op_sequencer
  import mpu_op_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int MATRIX_REG_SIZE = 2,
  parameter int MBITS           = 3,
  parameter int NBITS           = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid_in,
  input  mpu_operation_t             op_in,
  input  logic [MATRIX_REG_SIZE-1:0] op_addr_in,
  input  logic [MBITS:0]             op_m_size_in,
  input  logic [NBITS:0]             op_n_size_in,
  output logic                       op_ready_out,
  output logic                       load_en_out,
  output logic                       store_en_out,
  output logic [MATRIX_REG_SIZE-1:0] seq_addr_out,
  output logic [MBITS:0]             seq_m_size_out,
  output logic [NBITS:0]             seq_n_size_out,
  input  logic                       mem_load_ack_in,
  input  logic                       mem_load_error_in,
  input  logic                       reg_store_complete_in,
  output logic                       done_out,
  output logic [1:0]                 error_out,
  output logic                       busy_out
);

  localparam int NUM_MREGS = 2 ** MATRIX_REG_SIZE;
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_ISSUE,
    S_LOAD_WAIT,
    S_STORE_ISSUE,
    S_STORE_WAIT,
    S_FINISH
  } state_t;

  state_t                     state_reg, state_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next, cnt_inc;
  logic [1:0]                 err_reg, err_next;
  logic [MATRIX_REG_SIZE-1:0] addr_reg;
  logic [MBITS:0]             m_reg;
  logic [NBITS:0]             n_reg;
  logic [NUM_MREGS-1:0]       sb_reg;
  logic                       sb_set, sb_clr;
  logic                       accept, timeout_hit;

  assign accept      = (state_reg == S_IDLE) && op_valid_in;
  assign cnt_inc     = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // The counter is zero during the ISSUE cycle and advances from there, so a silent unit
  // is given up on exactly TIMEOUT_CYCLES cycles after its start pulse.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    sb_set     = 1'b0;
    sb_clr     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (op_valid_in) begin
          cnt_next = '0;
          err_next = 2'd0;
          case (op_in)
            MPU_LOAD:  state_next = S_LOAD_ISSUE;
            MPU_STORE: begin
              if (sb_reg[op_addr_in]) begin
                state_next = S_STORE_ISSUE;
              end else begin
                state_next = S_FINISH;
                err_next   = 2'd2;
              end
            end
            default:   state_next = S_FINISH;
          endcase
        end
      end
      S_LOAD_ISSUE: begin
        state_next = S_LOAD_WAIT;
        cnt_next   = cnt_inc;
      end
      S_LOAD_WAIT: begin
        if (mem_load_error_in) begin
          state_next = S_FINISH;
          err_next   = 2'd1;
          sb_clr     = 1'b1;
        end else if (mem_load_ack_in) begin
          state_next = S_FINISH;
          err_next   = 2'd0;
          sb_set     = 1'b1;
        end else if (timeout_hit) begin
          state_next = S_FINISH;
          err_next   = 2'd3;
          sb_clr     = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      S_STORE_ISSUE: begin
        state_next = S_STORE_WAIT;
        cnt_next   = cnt_inc;
      end
      S_STORE_WAIT: begin
        if (reg_store_complete_in) begin
          state_next = S_FINISH;
          err_next   = 2'd0;
        end else if (timeout_hit) begin
          state_next = S_FINISH;
          err_next   = 2'd3;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 2'd0;
      addr_reg  <= '0;
      m_reg     <= '0;
      n_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      if (accept) begin
        addr_reg <= op_addr_in;
        m_reg    <= op_m_size_in;
        n_reg    <= op_n_size_in;
      end
    end
  end

  // One valid bit per matrix register, updated only for the register the finished LOAD targeted.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MREGS; gi++) begin : g_sb
      always_ff @(posedge clk) begin
        if (rst) begin
          sb_reg[gi] <= 1'b0;
        end else if (addr_reg == MATRIX_REG_SIZE'(gi)) begin
          if (sb_set) begin
            sb_reg[gi] <= 1'b1;
          end else if (sb_clr) begin
            sb_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign op_ready_out   = (state_reg == S_IDLE);
  assign busy_out       = (state_reg != S_IDLE);
  assign load_en_out    = (state_reg == S_LOAD_ISSUE);
  assign store_en_out   = (state_reg == S_STORE_ISSUE);
  assign done_out       = (state_reg == S_FINISH);
  assign error_out      = done_out ? err_reg : 2'd0;
  assign seq_addr_out   = addr_reg;
  assign seq_m_size_out = m_reg;
  assign seq_n_size_out = n_reg;

endmodule

// File: tb/tb_mpu_op_sequencer.sv
// Bench for mpu_op_sequencer: directed vector table, reset-mid-operation sequence,
// and random operations checked against a transaction-level model of the sequencer.
module tb_mpu_op_sequencer;
  import mpu_op_pkg::*;

  localparam int TO  = 64;
  localparam int MRS = 2;
  localparam int MB  = 3;
  localparam int NB  = 3;
  localparam int NREG = 2 ** MRS;

  localparam int K_NONE = 0, K_ACK = 1, K_ERR = 2, K_BOTH = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           op_valid_in;
  mpu_operation_t op_in;
  logic [MRS-1:0] op_addr_in;
  logic [MB:0]    op_m_size_in;
  logic [NB:0]    op_n_size_in;
  logic           op_ready_out, load_en_out, store_en_out;
  logic [MRS-1:0] seq_addr_out;
  logic [MB:0]    seq_m_size_out;
  logic [NB:0]    seq_n_size_out;
  logic           mem_load_ack_in, mem_load_error_in, reg_store_complete_in;
  logic           done_out;
  logic [1:0]     error_out;
  logic           busy_out;

  mpu_op_sequencer #(
    .TIMEOUT_CYCLES(TO), .MATRIX_REG_SIZE(MRS), .MBITS(MB), .NBITS(NB)
  ) dut (
    .clk(clk), .rst(rst),
    .op_valid_in(op_valid_in), .op_in(op_in), .op_addr_in(op_addr_in),
    .op_m_size_in(op_m_size_in), .op_n_size_in(op_n_size_in),
    .op_ready_out(op_ready_out), .load_en_out(load_en_out), .store_en_out(store_en_out),
    .seq_addr_out(seq_addr_out), .seq_m_size_out(seq_m_size_out), .seq_n_size_out(seq_n_size_out),
    .mem_load_ack_in(mem_load_ack_in), .mem_load_error_in(mem_load_error_in),
    .reg_store_complete_in(reg_store_complete_in),
    .done_out(done_out), .error_out(error_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op; int addr; int m; int n; int kind; int d;
    int e_load; int e_store; int e_done; int e_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit msb [NREG];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int op, int addr, int m, int n, int kind, int d,
                              int e_load, int e_store, int e_done, int e_err);
    vec_t v;
    v.op = op; v.addr = addr; v.m = m; v.n = n; v.kind = kind; v.d = d;
    v.e_load = e_load; v.e_store = e_store; v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  // Outcome of one op from the rules: a response d cycles after the start pulse counts
  // only if it lands in a wait cycle before the give-up point (d in 1..TO-1).
  task automatic model(inout vec_t v);
    bit in_range;
    in_range = (v.d >= 1) && (v.d <= TO - 1);
    v.e_load = 0; v.e_store = 0; v.e_done = 1; v.e_err = 0;
    if (v.op == 1) begin
      v.e_load = 1;
      if (in_range && (v.kind == K_ERR || v.kind == K_BOTH)) begin
        v.e_err = 1; v.e_done = 2 + v.d; msb[v.addr] = 1'b0;
      end else if (in_range && v.kind == K_ACK) begin
        v.e_err = 0; v.e_done = 2 + v.d; msb[v.addr] = 1'b1;
      end else begin
        v.e_err = 3; v.e_done = 1 + TO; msb[v.addr] = 1'b0;
      end
    end else if (v.op == 2) begin
      if (!msb[v.addr]) begin
        v.e_err = 2;
      end else begin
        v.e_store = 1;
        if (in_range && (v.kind == K_ACK || v.kind == K_BOTH)) begin
          v.e_err = 0; v.e_done = 2 + v.d;
        end else begin
          v.e_err = 3; v.e_done = 1 + TO;
        end
      end
    end
  endtask

  // Cycle index t counts negedges after the accepting edge; inputs set at a negedge
  // are sampled by the following posedge.
  task automatic run_op(input vec_t v, input int idx);
    int t_done, n_ld, n_st, t_en, err_seen, addr_seen, m_seen, n_seen, busy_seen;
    bit resp;
    @(negedge clk);
    check("ready_before", op_ready_out, 1);
    op_valid_in  = 1'b1;
    op_in        = mpu_operation_t'(v.op[1:0]);
    op_addr_in   = MRS'(v.addr);
    op_m_size_in = (MB+1)'(v.m);
    op_n_size_in = (NB+1)'(v.n);
    mem_load_ack_in = 1'b0; mem_load_error_in = 1'b0; reg_store_complete_in = 1'b0;
    t_done = -1; n_ld = 0; n_st = 0; t_en = 0;
    err_seen = 0; addr_seen = 0; m_seen = 0; n_seen = 0; busy_seen = 0;
    for (int t = 1; t <= 100 && t_done < 0; t++) begin
      @(negedge clk);
      op_valid_in  = 1'b0;
      op_addr_in   = MRS'($urandom);
      op_m_size_in = (MB+1)'($urandom);
      op_n_size_in = (NB+1)'($urandom);
      if (load_en_out)  begin n_ld++; t_en = t; end
      if (store_en_out) begin n_st++; t_en = t; end
      resp = (t_en > 0) && (t == t_en + v.d);
      if (resp) begin
        mem_load_ack_in       = (v.kind == K_ACK || v.kind == K_BOTH);
        mem_load_error_in     = (v.kind == K_ERR || v.kind == K_BOTH);
        reg_store_complete_in = (v.kind == K_ACK || v.kind == K_BOTH);
      end else if (t == 1) begin
        mem_load_ack_in       = 1'($urandom);
        mem_load_error_in     = 1'($urandom);
        reg_store_complete_in = 1'($urandom);
      end else begin
        mem_load_ack_in = 1'b0; mem_load_error_in = 1'b0; reg_store_complete_in = 1'b0;
      end
      if (done_out) begin
        t_done = t; err_seen = error_out; busy_seen = busy_out;
        addr_seen = seq_addr_out; m_seen = seq_m_size_out; n_seen = seq_n_size_out;
      end
    end
    @(negedge clk);
    mem_load_ack_in = 1'b0; mem_load_error_in = 1'b0; reg_store_complete_in = 1'b0;
    check("done_pulse_len", done_out, 0);
    check("ready_after", op_ready_out, 1);
    check("load_en_count", n_ld, v.e_load);
    check("store_en_count", n_st, v.e_store);
    if (v.e_load + v.e_store > 0) check("en_cycle", t_en, 1);
    if (t_done < 0) begin
      check("done_seen", 0, 1);
    end else begin
      check("done_cycle", t_done, v.e_done);
      check("error_code", err_seen, v.e_err);
      check("busy_in_finish", busy_seen, 1);
      check("seq_addr", addr_seen, v.addr);
      check("seq_m", m_seen, v.m);
      check("seq_n", n_seen, v.n);
    end
    $display("op %0d: op=%0d addr=%0d kind=%0d d=%0d -> done@%0d err=%0d (exp done@%0d err=%0d)",
             idx, v.op, v.addr, v.kind, v.d, t_done, err_seen, v.e_done, v.e_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) msb[i] = 1'b0;
  endtask

  vec_t tbl [19];

  initial begin
    // op: 0 NOP, 1 LOAD, 2 STORE, 3 undefined
    tbl[0]  = mk(1, 0, 3, 3,   K_ACK,  9, 1, 0, 11, 0);
    tbl[1]  = mk(2, 1, 0, 0,   K_NONE, 0, 0, 0, 1,  2);
    tbl[2]  = mk(2, 0, 1, 2,   K_ACK,  5, 0, 1, 7,  0);
    tbl[3]  = mk(1, 0, 4, 5,   K_BOTH, 3, 1, 0, 5,  1);
    tbl[4]  = mk(2, 0, 0, 0,   K_ACK,  2, 0, 0, 1,  2);
    tbl[5]  = mk(1, 2, 15, 15, K_ACK,  63, 1, 0, 65, 0);
    tbl[6]  = mk(2, 2, 7, 8,   K_NONE, 0, 0, 1, 65, 3);
    tbl[7]  = mk(2, 2, 2, 3,   K_ACK,  64, 0, 1, 65, 3);
    tbl[8]  = mk(2, 2, 9, 1,   K_ACK,  63, 0, 1, 65, 0);
    tbl[9]  = mk(1, 2, 6, 6,   K_NONE, 0, 1, 0, 65, 3);
    tbl[10] = mk(2, 2, 1, 1,   K_ACK,  1, 0, 0, 1,  2);
    tbl[11] = mk(0, 3, 5, 10,  K_ACK,  1, 0, 0, 1,  0);
    tbl[12] = mk(3, 1, 12, 4,  K_ACK,  1, 0, 0, 1,  0);
    tbl[13] = mk(1, 3, 0, 0,   K_ACK,  1, 1, 0, 3,  0);
    tbl[14] = mk(2, 3, 11, 13, K_ACK,  1, 0, 1, 3,  0);
    tbl[15] = mk(1, 3, 3, 3,   K_ACK,  0, 1, 0, 65, 3);
    tbl[16] = mk(2, 3, 3, 3,   K_ACK,  1, 0, 0, 1,  2);
    tbl[17] = mk(1, 1, 2, 2,   K_ERR,  2, 1, 0, 4,  1);
    tbl[18] = mk(1, 1, 8, 7,   K_ACK,  4, 1, 0, 6,  0);

    rst = 1'b1; op_valid_in = 1'b0; op_in = MPU_NOP; op_addr_in = '0;
    op_m_size_in = '0; op_n_size_in = '0;
    mem_load_ack_in = 1'b0; mem_load_error_in = 1'b0; reg_store_complete_in = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_ready", op_ready_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_error", error_out, 0);
    check("rst_load_en", load_en_out, 0);
    check("rst_store_en", store_en_out, 0);
    check("rst_seq_addr", seq_addr_out, 0);
    check("rst_seq_m", seq_m_size_out, 0);
    $display("reset state checked");

    for (int i = 0; i < 19; i++) run_op(tbl[i], i);
    // Register 1 loaded; a STORE with only a stray load error never completes.
    run_op(mk(2, 1, 8, 7, K_ERR, 3, 0, 1, 65, 3), 19);

    // Reset while waiting on a load, with a STORE held on the request lines.
    @(negedge clk);
    op_valid_in = 1'b1; op_in = MPU_LOAD; op_addr_in = 2'd1;
    op_m_size_in = 4'd5; op_n_size_in = 4'd6;
    @(negedge clk);
    op_valid_in = 1'b0;
    check("mid_rst_load_en", load_en_out, 1);
    @(negedge clk);
    check("mid_rst_busy_wait", busy_out, 1);
    rst = 1'b1; op_valid_in = 1'b1; op_in = MPU_STORE; op_addr_in = 2'd1;
    op_m_size_in = 4'd2; op_n_size_in = 4'd2;
    @(negedge clk);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_done", done_out, 0);
    check("mid_rst_load_en", load_en_out, 0);
    check("mid_rst_ready", op_ready_out, 1);
    check("mid_rst_seq_addr", seq_addr_out, 0);
    rst = 1'b0;
    @(negedge clk);
    op_valid_in = 1'b0;
    check("post_rst_done", done_out, 1);
    check("post_rst_err", error_out, 2);
    check("post_rst_store_en", store_en_out, 0);
    check("post_rst_seq_addr", seq_addr_out, 1);
    @(negedge clk);
    check("post_rst_done_low", done_out, 0);
    $display("reset mid-op: done=%0d err=%0d after restart", done_out, error_out);

    do_reset();
    for (int i = 0; i < 150; i++) begin
      vec_t v;
      int r;
      r = $urandom_range(0, 7);
      v.op   = (r == 0) ? 0 : (r == 1) ? 3 : (r <= 4) ? 1 : 2;
      v.addr = $urandom_range(0, NREG - 1);
      v.m    = $urandom_range(0, 15);
      v.n    = $urandom_range(0, 15);
      v.kind = $urandom_range(0, 3);
      r = $urandom_range(0, 11);
      v.d = (r == 0) ? 0 : (r == 1) ? TO - 1 : (r == 2) ? TO : (r == 3) ? TO - 2 : $urandom_range(1, 12);
      model(v);
      run_op(v, 100 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
